pic_param_core: RTL and testbench

Clocked, parametrised successor to the 8259-style PIC datapath (IRR/IMR/ISR/priority resolver/control logic) in a single synchronous block.
- Supports 1..16 request lines, edge or level triggering, fixed or rotating priority, and a programmable vector base.
- Uses a single-pulse INTA vector handshake.
- Sits between the peripheral request lines and the CPU bus/interrupt interface; cascade is out of scope.

---
 rtl/pic_pkg.sv | 41 ++++
 rtl/pic_rot_prio_enc.sv | 38 +++
 rtl/pic_param_core.sv | 197 +++++++++++++++++++
 tb/tb_pic_param_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM states, register map, command bit positions and priority helper for pic_param_core.
// Rev 1.0
`default_nettype none

package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } pic_state_e;

  localparam logic [2:0] ADDR_CMD    = 3'd0;
  localparam logic [2:0] ADDR_IMR_LO = 3'd1;
  localparam logic [2:0] ADDR_IMR_HI = 3'd2;
  localparam logic [2:0] ADDR_BASE   = 3'd3;
  localparam logic [2:0] ADDR_IRR_LO = 3'd4;
  localparam logic [2:0] ADDR_IRR_HI = 3'd5;
  localparam logic [2:0] ADDR_ISR_LO = 3'd6;
  localparam logic [2:0] ADDR_ISR_HI = 3'd7;

  localparam int CMD_EOI  = 7;
  localparam int CMD_SPEC = 6;
  localparam int CMD_ROT  = 5;
  localparam int CMD_LVL  = 4;
  localparam int CMD_AEOI = 3;

  localparam logic [7:0] RESET_VBASE = 8'h08;

  // Rank 0 is the highest priority: the line just after rot_ptr.
  function automatic logic [4:0] prio_rank(input logic [3:0] idx, input logic [3:0] rot_ptr,
                                           input int n);
    int r;
    r = int'(idx) - int'(rot_ptr) - 1;
    if (r < 0) r = r + n;
    return r[4:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pic_rot_prio_enc.sv
// pic_rot_prio_enc: picks the highest-priority set bit, priority starting at rot_ptr+1 and wrapping.
// Rev 1.0
`default_nettype none

module pic_rot_prio_enc
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_IRQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rot_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [15:0] req_pad;
  assign req_pad = 16'(req_i);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int p;
    valid_o = 1'b0;
    idx_o   = '0;
    p       = 0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      p = int'(rot_ptr_i) + 1 + k;
      if (p >= NUM_IRQ) p = p - NUM_IRQ;
      if (req_pad[p[3:0]]) begin
        valid_o = 1'b1;
        idx_o   = p[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pic_param_core.sv
// pic_param_core: parametrised 8259-style interrupt controller; optional auto-EOI via PIC_AUTO_EOI_EN.
// Rev 1.0
`default_nettype none

module pic_param_core
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cs,
  input  logic               wr,
  input  logic               rd,
  input  logic [2:0]         addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               int_o,
  input  logic               inta,
  output logic [7:0]         vector_o,
  output logic               vector_valid
);

  pic_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, irq_prev_q;
  logic [7:0]         base_q, base_d, vector_q, vector_d;
  logic               vv_q, vv_d, level_q, level_d, rot_q, rot_d;
  logic [IDX_W-1:0]   rot_ptr_q, rot_ptr_d;

  logic               cand_raw, cand_valid, isr_top_valid, ack_fire, cmd_wr, eoi_wr, eoi_hit;
  logic [IDX_W-1:0]   cand_idx, isr_top_idx, eoi_idx, eoi_lvl;
  logic [NUM_IRQ-1:0] ack_mask, eoi_mask, aeoi_mask;
  logic [15:0]        imr_full, isr_pad, irr_pad;
  logic               aeoi_hit;
  logic [IDX_W-1:0]   aeoi_idx;

  pic_rot_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_cand_enc (
    .req_i(irr_q & ~imr_q), .rot_ptr_i(rot_ptr_q), .valid_o(cand_raw), .idx_o(cand_idx)
  );

  pic_rot_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_isr_enc (
    .req_i(isr_q), .rot_ptr_i(rot_ptr_q), .valid_o(isr_top_valid), .idx_o(isr_top_idx)
  );

  // Fully nested: a request only competes if it outranks everything in service.
  assign cand_valid = cand_raw && (!isr_top_valid ||
                      (prio_rank(cand_idx, rot_ptr_q, NUM_IRQ) < prio_rank(isr_top_idx, rot_ptr_q, NUM_IRQ)));
  assign ack_fire   = inta && (state_q == PEND) && cand_valid;
  assign cmd_wr     = cs && wr && (addr == ADDR_CMD);
  assign eoi_wr     = cmd_wr && wdata[CMD_EOI];
  assign isr_pad    = 16'(isr_q);
  assign irr_pad    = 16'(irr_q);

`ifdef PIC_AUTO_EOI_EN
  logic             aeoi_q, aeoi_d;
  logic [IDX_W-1:0] ack_idx_q, ack_idx_d;

  assign eoi_lvl   = {1'b0, wdata[2:0]};
  assign aeoi_d    = (cmd_wr && !wdata[CMD_EOI]) ? wdata[CMD_AEOI] : aeoi_q;
  assign ack_idx_d = ack_fire ? cand_idx : ack_idx_q;
  assign aeoi_hit  = aeoi_q && (state_q == ACK);
  assign aeoi_idx  = ack_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aeoi_q    <= 1'b0;
      ack_idx_q <= '0;
    end else begin
      aeoi_q    <= aeoi_d;
      ack_idx_q <= ack_idx_d;
    end
  end
`else
  assign eoi_lvl  = wdata[3:0];
  assign aeoi_hit = 1'b0;
  assign aeoi_idx = '0;
`endif

  always_comb begin
    eoi_hit = 1'b0;
    eoi_idx = '0;
    if (eoi_wr) begin
      if (wdata[CMD_SPEC]) begin
        if (({1'b0, eoi_lvl} < 5'(NUM_IRQ)) && isr_pad[eoi_lvl]) begin
          eoi_hit = 1'b1;
          eoi_idx = eoi_lvl;
        end
      end else if (isr_top_valid) begin
        eoi_hit = 1'b1;
        eoi_idx = isr_top_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_mask[i]  = ack_fire && (cand_idx == IDX_W'(i));
      eoi_mask[i]  = eoi_hit && (eoi_idx == IDX_W'(i));
      aeoi_mask[i] = aeoi_hit && (aeoi_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    level_d   = level_q;
    rot_d     = rot_q;
    rot_ptr_d = rot_ptr_q;
    vv_d      = 1'b0;
    vector_d  = vector_q;
    imr_full  = 16'(imr_q);

    // A fresh edge on the line being acked re-sets IRR in the same cycle.
    if (level_q) irr_d = irq_in & ~ack_mask;
    else         irr_d = (irr_q & ~ack_mask) | (irq_in & ~irq_prev_q);
    isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | ack_mask;

    if (cmd_wr && !wdata[CMD_EOI]) begin
      rot_d   = wdata[CMD_ROT];
      level_d = wdata[CMD_LVL];
    end
    if (cs && wr && (addr == ADDR_IMR_LO)) imr_full[7:0]  = wdata;
    if (cs && wr && (addr == ADDR_IMR_HI)) imr_full[15:8] = wdata;
    if (cs && wr && (addr == ADDR_BASE))   base_d = wdata;
    imr_d = imr_full[NUM_IRQ-1:0];

    if (eoi_hit && rot_q)  rot_ptr_d = eoi_idx;
    if (aeoi_hit && rot_q) rot_ptr_d = aeoi_idx;

    if (inta) begin
      vv_d     = 1'b1;
      vector_d = ack_fire ? (base_q + 8'(cand_idx)) : (base_q + 8'(NUM_IRQ));
    end

    case (state_q)
      IDLE:    if (cand_valid) state_d = PEND;
      PEND:    if (ack_fire) state_d = ACK;
               else if (!cand_valid) state_d = IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (cs && rd) begin
      case (addr)
        ADDR_CMD:    rdata = {int_o, |isr_q, 2'b00, isr_top_idx};
        ADDR_IMR_LO: rdata = 16'(imr_q) >> 0;
        ADDR_IMR_HI: rdata = 8'(16'(imr_q) >> 8);
        ADDR_BASE:   rdata = base_q;
        ADDR_IRR_LO: rdata = irr_pad[7:0];
        ADDR_IRR_HI: rdata = irr_pad[15:8];
        ADDR_ISR_LO: rdata = isr_pad[7:0];
        ADDR_ISR_HI: rdata = isr_pad[15:8];
        default:     rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irr_q      <= '0;
      isr_q      <= '0;
      imr_q      <= '0;
      irq_prev_q <= '0;
      base_q     <= RESET_VBASE;
      vector_q   <= '0;
      vv_q       <= 1'b0;
      level_q    <= 1'b0;
      rot_q      <= 1'b0;
      rot_ptr_q  <= IDX_W'(NUM_IRQ - 1);
    end else begin
      state_q    <= state_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      irq_prev_q <= irq_in;
      base_q     <= base_d;
      vector_q   <= vector_d;
      vv_q       <= vv_d;
      level_q    <= level_d;
      rot_q      <= rot_d;
      rot_ptr_q  <= rot_ptr_d;
    end
  end

  assign int_o        = (state_q == PEND);
  assign vector_o     = vector_q;
  assign vector_valid = vv_q;

endmodule

`default_nettype wire

// File: tb/tb_pic_param_core.sv
// tb_pic_param_core: directed scoreboard bench for an 8-line and a 16-line pic_param_core.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_pic_param_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [2:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  irq8 = '0;
  logic [15:0] irq16 = '0;
  logic        inta8 = 1'b0, inta16 = 1'b0;
  logic [7:0]  rdata8, rdata16, vec8, vec16;
  logic        int8, int16, vv8, vv16;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  q8[$];
  logic [7:0]  q16[$];

  always #5 clk = ~clk;

  pic_param_core #(.NUM_IRQ(8), .IDX_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata8), .irq_in(irq8), .int_o(int8), .inta(inta8), .vector_o(vec8),
    .vector_valid(vv8)
  );

  pic_param_core #(.NUM_IRQ(16), .IDX_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata16), .irq_in(irq16), .int_o(int16), .inta(inta16), .vector_o(vec16),
    .vector_valid(vv16)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input bit sel16, input logic [2:0] a,
                        input logic [7:0] exp);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    chk(name, sel16 ? rdata16 : rdata8, exp);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic ack(input bit sel16, input logic [7:0] exp);
    if (sel16) begin q16.push_back(exp); inta16 = 1'b1; end
    else       begin q8.push_back(exp);  inta8  = 1'b1; end
    tick();
    inta8 = 1'b0; inta16 = 1'b0;
  endtask

  task automatic wait_int(input string name, input bit sel16);
    bit seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if ((sel16 ? int16 : int8) === 1'b1) seen = 1'b1;
      else tick();
    end
    chk(name, 16'(seen), 16'd1);
  endtask

  // Scoreboard monitor: every vector_valid pulse must match the oldest expected vector.
  always @(negedge clk) begin
    logic [7:0] e;
    if (vv8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL vec8_unexpected: got %h expected none", vec8);
      end else begin
        e = q8.pop_front();
        chk("vec8", 16'(vec8), 16'(e));
      end
    end
    if (vv16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL vec16_unexpected: got %h expected none", vec16);
      end else begin
        e = q16.pop_front();
        chk("vec16", 16'(vec16), 16'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk("rst_int8", 16'(int8), 16'd0);
    chk("rst_vv8", 16'(vv8), 16'd0);
    chk("rst_vec8", 16'(vec8), 16'd0);
    chk("rst_rdata8", 16'(rdata8), 16'd0);
    rd_chk("rst_base8", 1'b0, 3'd3, 8'h08);
    rd_chk("rst_imr8", 1'b0, 3'd1, 8'h00);
    rst_n = 1'b1;
    tick();

    // Edge on line 3 with base 0x20
    wr_reg(3'd3, 8'h20);
    irq8[3] = 1'b1;
    tick(); chk("t1_int_lat1", 16'(int8), 16'd0);
    tick(); chk("t1_int_lat2", 16'(int8), 16'd1);
    ack(1'b0, 8'h23);
    chk("t1_int_ack", 16'(int8), 16'd0);
    rd_chk("t1_isr", 1'b0, 3'd6, 8'h08);
    rd_chk("t1_irr", 1'b0, 3'd4, 8'h00);
    rd_chk("t1_stat", 1'b0, 3'd0, 8'h43);
    irq8[3] = 1'b0;
    tick();
    wr_reg(3'd0, 8'h80);
    rd_chk("t1_eoi", 1'b0, 3'd6, 8'h00);

    // Nesting: 5 in service, 2 preempts, 6 waits for 5
    irq8[5] = 1'b1;
    wait_int("t2_int5", 1'b0);
    irq8[5] = 1'b0;
    ack(1'b0, 8'h25);
    rd_chk("t2_isr5", 1'b0, 3'd6, 8'h20);
    tick();
    irq8[6] = 1'b1; irq8[2] = 1'b1;
    tick(); tick();
    chk("t2_int2", 16'(int8), 16'd1);
    irq8[6] = 1'b0; irq8[2] = 1'b0;
    ack(1'b0, 8'h22);
    rd_chk("t2_isr", 1'b0, 3'd6, 8'h24);
    rd_chk("t2_irr", 1'b0, 3'd4, 8'h40);
    wr_reg(3'd0, 8'hC9);
    rd_chk("t2_spec9", 1'b0, 3'd6, 8'h24);
    wr_reg(3'd0, 8'h80);
    rd_chk("t2_eoi2", 1'b0, 3'd6, 8'h20);
    tick(); tick();
    chk("t2_no6", 16'(int8), 16'd0);
    wr_reg(3'd0, 8'hC5);
    rd_chk("t2_spec5", 1'b0, 3'd6, 8'h00);
    tick();
    chk("t2_int6", 16'(int8), 16'd1);
    ack(1'b0, 8'h26);
    wr_reg(3'd0, 8'h80);
    rd_chk("t2_isr_clr", 1'b0, 3'd6, 8'h00);

    // Rotate on EOI with lines 0 and 1 held in level mode
    wr_reg(3'd0, 8'h30);
    irq8[1:0] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_int("t3_int", 1'b0);
      ack(1'b0, 8'h20 + 8'(i % 2));
      rd_chk("t3_stat", 1'b0, 3'd0, 8'h40 | 8'(i % 2));
      wr_reg(3'd0, 8'h80);
    end
    irq8[1:0] = 2'b00;
    wr_reg(3'd0, 8'h00);
    tick(); tick();
    chk("t3_idle", 16'(int8), 16'd0);
    rd_chk("t3_irr", 1'b0, 3'd4, 8'h00);

    // Mask while pending
    irq8[4] = 1'b1;
    wait_int("t4_int", 1'b0);
    wr_reg(3'd1, 8'h10);
    chk("t4_int_hold", 16'(int8), 16'd1);
    tick();
    chk("t4_int_drop", 16'(int8), 16'd0);
    rd_chk("t4_irr", 1'b0, 3'd4, 8'h10);
    rd_chk("t4_imr", 1'b0, 3'd1, 8'h10);
    wr_reg(3'd1, 8'h00);
    tick();
    chk("t4_int_back", 16'(int8), 16'd1);
    irq8[4] = 1'b0;
    ack(1'b0, 8'h24);
    wr_reg(3'd0, 8'h80);
    rd_chk("t4_isr", 1'b0, 3'd6, 8'h00);

    // Spurious acknowledge
    wr_reg(3'd3, 8'h40);
    ack(1'b0, 8'h48);
    ack(1'b1, 8'h50);
    rd_chk("t5_isr", 1'b0, 3'd6, 8'h00);
    rd_chk("t5_irr", 1'b0, 3'd4, 8'h00);
    wr_reg(3'd3, 8'h20);

    // Sixteen lines: upper byte registers and reset during ACK
    irq16[12] = 1'b1;
    wait_int("t6_int", 1'b1);
    rd_chk("t6_irrhi", 1'b1, 3'd5, 8'h10);
    ack(1'b1, 8'h2C);
    rd_chk("t6_isrhi", 1'b1, 3'd7, 8'h10);
    rd_chk("t6_irrhi_clr", 1'b1, 3'd5, 8'h00);
    irq16[12] = 1'b0;
    tick();
    wr_reg(3'd0, 8'h80);
    rd_chk("t6_eoi", 1'b1, 3'd7, 8'h00);
    irq16[12] = 1'b1;
    wait_int("t6_int2", 1'b1);
    irq16[12] = 1'b0;
    inta16 = 1'b1;
    tick();
    inta16 = 1'b0;
    chk("t6_vv_ack", 16'(vv16), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vv", 16'(vv16), 16'd0);
    chk("t6_rst_vec", 16'(vec16), 16'd0);
    chk("t6_rst_int", 16'(int16), 16'd0);
    rd_chk("t6_rst_isr", 1'b1, 3'd7, 8'h00);
    rd_chk("t6_rst_base", 1'b1, 3'd3, 8'h08);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("q8_empty", 16'(q8.size()), 16'd0);
    chk("q16_empty", 16'(q16.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
